// File: rtl/sf_camera_capture.sv
// sf_camera_capture: parallel camera bus receiver packing bytes into big-endian 32-bit FIFO words
//   clk, rst                 pixel clock, synchronous active-high reset
//   i_enable, i_continuous   capture control (single-shot on enable rise, or back-to-back)
//   i_vsync, i_hsync         frame / line valid from the camera pins
//   i_pix_data               pixel byte, valid when vsync & hsync
//   o_fifo_wr_data/_stb      packed word and 1-cycle write strobe; i_fifo_full drops the word
//   o_frame_done             1-cycle pulse at frame end, o_row_count holds that frame's rows
//   o_row_err, o_overflow    sticky error flags, cleared when a new capture is armed
//   o_busy                   capture engine not idle
module sf_camera_capture #(
    parameter logic [31:0] BYTE_COUNT = 32'h20,
    parameter logic [31:0] ROW_COUNT  = 32'h10
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        i_enable,
    input  logic        i_continuous,
    input  logic        i_vsync,
    input  logic        i_hsync,
    input  logic [7:0]  i_pix_data,
    output logic [31:0] o_fifo_wr_data,
    output logic        o_fifo_wr_stb,
    input  logic        i_fifo_full,
    output logic        o_frame_done,
    output logic [31:0] o_row_count,
    output logic        o_row_err,
    output logic        o_overflow,
    output logic        o_busy
);
    typedef enum logic [2:0] {IDLE, SYNC, WAIT_FRAME, CAPTURE, DONE} state_t;
    state_t      state_q;
    logic        vs_q, hs_q, vs_prev_q, val_prev_q, en_q;
    logic [7:0]  pd_q;
    logic [1:0]  idx_q;
    logic [23:0] word_q;
    logic [31:0] row_bytes_q, rows_q;
    logic        byte_v, row_end, vs_rise, vs_fall, emit_d;
    logic [31:0] row_bytes_d, rows_d, rows_fin_d, word_d;

    // A row ends when byte-valid drops, whichever of hsync/vsync caused it.
    // A partial word keeps its bytes in the low end of word_q; the shift moves
    // them to the top and leaves the unused low bytes zero.
    always_comb begin
        byte_v      = vs_q & hs_q;
        row_end     = val_prev_q & ~byte_v;
        vs_rise     = vs_q & ~vs_prev_q;
        vs_fall     = ~vs_q & vs_prev_q;
        row_bytes_d = (&row_bytes_q) ? row_bytes_q : row_bytes_q + 32'd1;
        rows_d      = (&rows_q) ? rows_q : rows_q + 32'd1;
        rows_fin_d  = row_end ? rows_d : rows_q;
        emit_d      = (state_q == CAPTURE) && (byte_v ? (idx_q == 2'd3) : (row_end && idx_q != 2'd0));
        word_d      = byte_v ? {word_q, pd_q} : ({word_q, 8'h00} << {~idx_q, 3'b000});
    end

    assign o_busy = state_q != IDLE;

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q        <= IDLE;
            vs_q           <= 1'b0;
            hs_q           <= 1'b0;
            pd_q           <= 8'h00;
            vs_prev_q      <= 1'b0;
            val_prev_q     <= 1'b0;
            en_q           <= 1'b0;
            idx_q          <= 2'd0;
            word_q         <= 24'h0;
            row_bytes_q    <= 32'h0;
            rows_q         <= 32'h0;
            o_fifo_wr_data <= 32'h0;
            o_fifo_wr_stb  <= 1'b0;
            o_frame_done   <= 1'b0;
            o_row_count    <= 32'h0;
            o_row_err      <= 1'b0;
            o_overflow     <= 1'b0;
        end else begin
            vs_q          <= i_vsync;
            hs_q          <= i_hsync;
            pd_q          <= i_pix_data;
            vs_prev_q     <= vs_q;
            val_prev_q    <= byte_v;
            en_q          <= i_enable;
            o_fifo_wr_stb <= emit_d & ~i_fifo_full;
            o_frame_done  <= 1'b0;
            if (emit_d && !i_fifo_full) o_fifo_wr_data <= word_d;
            if (emit_d && i_fifo_full) o_overflow <= 1'b1;
            case (state_q)
                IDLE: if (i_enable && (!en_q || i_continuous)) begin
                    state_q    <= SYNC;
                    o_row_err  <= 1'b0;
                    o_overflow <= 1'b0;
                end
                SYNC: if (!vs_q) state_q <= WAIT_FRAME;
                WAIT_FRAME: if (vs_rise) begin
                    state_q     <= CAPTURE;
                    rows_q      <= 32'h0;
                    row_bytes_q <= 32'h0;
                    idx_q       <= 2'd0;
                end
                CAPTURE: begin
                    if (byte_v) begin
                        idx_q       <= idx_q + 2'd1;
                        word_q      <= {word_q[15:0], pd_q};
                        row_bytes_q <= row_bytes_d;
                    end
                    if (row_end) begin
                        rows_q      <= rows_d;
                        row_bytes_q <= 32'h0;
                        idx_q       <= 2'd0;
                        if (row_bytes_q != BYTE_COUNT) o_row_err <= 1'b1;
                    end
                    // Frame end sees this cycle's row end already folded into the count.
                    if (vs_fall) begin
                        state_q      <= DONE;
                        o_frame_done <= 1'b1;
                        o_row_count  <= rows_fin_d;
                        if (rows_fin_d != ROW_COUNT) o_row_err <= 1'b1;
                    end
                end
                DONE: if (i_enable && i_continuous) begin
                    state_q    <= SYNC;
                    o_row_err  <= 1'b0;
                    o_overflow <= 1'b0;
                end else begin
                    state_q <= IDLE;
                end
                default: state_q <= IDLE;
            endcase
        end
    end
endmodule
